// File: rtl/pulsador_up_down_pkg.sv
// Shared types and constants for the push-button conditioner.
// Code = {sync_up, sync_down}.
package pulsador_up_down_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_UP   = 2'b10;
    localparam logic [1:0] CODE_DOWN = 2'b01;
    localparam logic [1:0] CODE_BOTH = 2'b11;

    function automatic logic is_press(input logic [1:0] code);
        return (code == CODE_UP) || (code == CODE_DOWN);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets asynchronously to all zeros.
module sincronizador_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pulsador_up_down.sv
// Up/down push-button conditioner: sync, debounce, one-shot
// and optional hold-to-repeat, producing clean counter steps.
module pulsador_up_down #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic rep_en,
    output logic up,
    output logic down,
    output logic EN
);

    import pulsador_up_down_pkg::*;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);

    logic [1:0]       code;
    state_t           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             en_q;
    logic             emit;

    sincronizador_2ff #(
        .W(2)
    ) u_sync (
        .clk_i(clk),
        .rst_i(rst),
        .d_i  ({btn_up, btn_down}),
        .q_o  (code)
    );

    assign cnt_inc = cnt_q + ONE;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_press(code)) begin
                    cand_d  = code;
                    cnt_d   = ONE;
                    state_d = PRESS_WAIT;
                end else if (code == CODE_BOTH) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (code == cand_q) begin
                    if (cnt_inc == DEB_C) begin
                        emit    = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else if (code == CODE_NONE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (code == CODE_BOTH) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end else begin
                    cand_d = code;
                    cnt_d  = ONE;
                end
            end
            HELD: begin
                if (code != cand_q) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end else if (rep_en) begin
                    if (cnt_inc == HOLD_C) begin
                        emit    = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            REPEAT: begin
                // Leaving wins over a pulse due in the same cycle
                if (code != cand_q || !rep_en) begin
                    cnt_d   = '0;
                    state_d = RELEASE_WAIT;
                end else if (cnt_inc == REP_C) begin
                    emit  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE_WAIT: begin
                if (code == CODE_NONE) begin
                    if (cnt_inc == DEB_C) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        up_d   = emit && (cand_q == CODE_UP);
        down_d = emit && (cand_q == CODE_DOWN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= CODE_NONE;
            cnt_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            down_q  <= down_d;
            en_q    <= up_d | down_d;
        end
    end

    assign up   = up_q;
    assign down = down_q;
    assign EN   = en_q;

endmodule

// File: tb/tb_pulsador_up_down.sv
// Bench for pulsador_up_down: directed timing cases plus random
// button traffic against a run-length based reference model.
module tb_pulsador_up_down;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic rep_en;
    logic up;
    logic down;
    logic EN;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pulsador_up_down #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .rep_en  (rep_en),
        .up      (up),
        .down    (down),
        .EN      (EN)
    );

    // Reference model state: synchronizer delay line, run length of
    // the current sampled code, and press/release bookkeeping.
    logic [1:0] m_s1, m_s2, m_prev, m_key;
    int         m_run, m_elapsed, m_quiet;
    bit         m_armed, m_pressing, m_rep_started;
    bit         e_up, e_down;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_prev = 2'b00; m_key = 2'b00;
        m_run = 0; m_elapsed = 0; m_quiet = 0;
        m_armed = 1'b1; m_pressing = 1'b0; m_rep_started = 1'b0;
        e_up = 1'b0; e_down = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] raw, input bit r);
        logic [1:0] c;
        c = m_s2;
        e_up = 1'b0;
        e_down = 1'b0;
        if (c == m_prev) m_run++;
        else m_run = 1;
        m_prev = c;
        if (m_armed) begin
            if ((c == 2'b10 || c == 2'b01) && m_run == D) begin
                e_up = (c == 2'b10);
                e_down = (c == 2'b01);
                m_armed = 1'b0;
                m_pressing = 1'b1;
                m_key = c;
                m_elapsed = 0;
                m_rep_started = 1'b0;
            end else if (c == 2'b11) begin
                m_armed = 1'b0;
                m_pressing = 1'b0;
                m_quiet = 0;
            end
        end else if (m_pressing) begin
            if (c != m_key || (m_rep_started && !r)) begin
                m_pressing = 1'b0;
                m_quiet = 0;
            end else if (r) begin
                m_elapsed++;
                if (m_elapsed == H ||
                    (m_elapsed > H && (m_elapsed - H) % R == 0)) begin
                    e_up = (m_key == 2'b10);
                    e_down = (m_key == 2'b01);
                end
                if (m_elapsed >= H) m_rep_started = 1'b1;
            end
        end else begin
            if (c == 2'b00) begin
                m_quiet++;
                if (m_quiet == D) m_armed = 1'b1;
            end else begin
                m_quiet = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step({btn_up, btn_down}, rep_en);
        #1;
        chk("up", 32'(up), 32'(e_up));
        chk("down", 32'(down), 32'(e_down));
        chk("EN", 32'(EN), 32'(e_up | e_down));
    endtask

    initial begin
        int first, second, pulses, len, nb;
        logic [1:0] pat;
        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        rep_en = 1'b0;
        model_reset();
        #1;
        chk("reset_up", 32'(up), 32'd0);
        chk("reset_EN", 32'(EN), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) tick();

        // Single press, no repeat: one pulse D+2 cycles after the rise
        btn_up = 1'b1;
        first = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (up) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 8) btn_up = 1'b0;
        end
        chk("lat_single", 32'(first), 32'd6);
        chk("cnt_single", 32'(pulses), 32'd1);

        // Held with repeat: 6, 16, then every 3 cycles until release
        rep_en = 1'b1;
        btn_up = 1'b1;
        first = 0; second = 0; pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (up) begin
                pulses++;
                if (pulses == 1) first = k;
                if (pulses == 2) second = k;
            end
            if (k == 40) btn_up = 1'b0;
        end
        chk("lat_rep1", 32'(first), 32'd6);
        chk("lat_rep2", 32'(second), 32'd16);
        chk("cnt_rep", 32'(pulses), 32'd10);

        // Reset mid-press: press restarts after reset release
        rep_en = 1'b0;
        btn_up = 1'b1;
        first = 0; pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (up) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 4) rst = 1'b1;
            if (k == 6) rst = 1'b0;
        end
        chk("lat_rst", 32'(first), 32'd12);
        chk("cnt_rst", 32'(pulses), 32'd1);
        btn_up = 1'b0;
        repeat (10) tick();

        // Random traffic with bounce, overlaps, repeat toggling, resets
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) tick();
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) rep_en = 1'($urandom_range(0, 1));
            pat = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) pat = 2'b00;
            len = int'($urandom_range(1, 35));
            nb = int'($urandom_range(0, 5));
            for (int i = 0; i < len; i++) begin
                if (i < nb) {btn_up, btn_down} = 2'($urandom_range(0, 3));
                else {btn_up, btn_down} = pat;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
